// File: rtl/mul_div_unit_pkg.sv
// Shared multiply/divide op encodings and FSM state type for the HI/LO unit.
package mul_div_unit_pkg;

  localparam int unsigned MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_arith.sv
// Combinational product, quotient and remainder for MULT/MULTU/DIV/DIVU.
module md_arith
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c,
  output logic             div_zero_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic             is_signed;
  logic             is_div;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    prod;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  always_comb begin
    is_signed  = (op == MD_MULT) || (op == MD_DIV);
    is_div     = (op == MD_DIV) || (op == MD_DIVU);
    div_zero_c = (b == '0);

    // Modular 2W-bit product is exact for both signed and unsigned extension.
    a_ext = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod  = a_ext * b_ext;

    // Sign-magnitude divide; most-negative / -1 wraps to most-negative, rem 0.
    a_neg  = is_signed & a[WIDTH-1];
    b_neg  = is_signed & b[WIDTH-1];
    a_mag  = a_neg ? WIDTH'(-a) : a;
    b_mag  = b_neg ? WIDTH'(-b) : b;
    b_safe = div_zero_c ? WIDTH'(1) : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? WIDTH'(-q_mag) : q_mag;
    rem    = a_neg ? WIDTH'(-r_mag) : r_mag;

    hi_c = is_div ? rem  : prod[PW-1:WIDTH];
    lo_c = is_div ? quot : prod[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: FSM, latency counter, pending result and HI/LO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic             busy_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH-1:0] arith_hi, arith_lo;
  logic             div_zero;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op         (md_op),
    .a          (in0),
    .b          (in1),
    .hi_c       (arith_hi),
    .lo_c       (arith_lo),
    .div_zero_c (div_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      busy      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      busy      <= busy_d;
      hi        <= hi_d;
      lo        <= lo_d;
    end
  end

  // Requests are only looked at in IDLE, so a start while busy is dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    busy_d    = busy;
    hi_d      = hi;
    lo_d      = lo;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op_e'(md_op))
            MD_MULT, MD_MULTU: begin
              state_d   = ST_BUSY;
              busy_d    = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              pend_hi_d = arith_hi;
              pend_lo_d = arith_lo;
              pend_wr_d = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              state_d   = ST_BUSY;
              busy_d    = 1'b1;
              cnt_d     = CNT_W'(DIV_CYCLES);
              pend_hi_d = arith_hi;
              pend_lo_d = arith_lo;
              pend_wr_d = ~div_zero;
            end
            MD_MTHI: hi_d = in0;
            MD_MTLO: lo_d = in0;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
